// File: rtl/alu_sequencer.sv
// alu_sequencer: control stage in front of the 8-bit ALU. Owns the A/B operand
// registers, turns one accepted request into ALU strobes, bus enables and
// flag-capture edges, and writes the ALU result bus back into A.
module alu_sequencer (
  input  logic       clk,
  input  logic       reset,
  output logic       resetBar,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [2:0] req_op,
  input  logic [7:0] req_data,
  output logic [7:0] areg,
  output logic [7:0] breg,
  output logic       doSubtract,
  output logic       doCarryIn,
  output logic       doShiftIn,
  output logic       assertBarE,
  output logic       assertBarS,
  output logic       triggerC,
  output logic       triggerS,
  input  logic [7:0] dbus,
  input  logic       aIsZero,
  input  logic       flagCarry,
  input  logic       flagShift,
  output logic       done,
  output logic       zero
);

  localparam int unsigned DATA_W = 8;
  localparam int unsigned OP_W   = 3;

  localparam logic [OP_W-1:0] OP_LDA = 3'd0;
  localparam logic [OP_W-1:0] OP_ADD = 3'd1;
  localparam logic [OP_W-1:0] OP_ADC = 3'd2;
  localparam logic [OP_W-1:0] OP_SUB = 3'd3;
  localparam logic [OP_W-1:0] OP_SBC = 3'd4;
  localparam logic [OP_W-1:0] OP_LSR = 3'd5;
  localparam logic [OP_W-1:0] OP_ROR = 3'd6;
  localparam logic [OP_W-1:0] OP_NOP = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_FLAG = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [DATA_W-1:0] res_q, res_d;

  logic accept;
  logic arith_d;
  logic shift_d;
  logic long_op;
  logic active_d;

  logic ready_q, ready_d;
  logic sub_q, sub_d;
  logic cin_q, cin_d;
  logic shin_q, shin_d;
  logic bar_e_q, bar_e_d;
  logic bar_s_q, bar_s_d;
  logic trig_c_q, trig_c_d;
  logic trig_s_q, trig_s_d;
  logic done_q, done_d;
  logic rstb_q;

  // ALU flags are consumed by the ALU datapath itself; sequencing does not need them.
  logic unused_status;
  assign unused_status = flagCarry ^ flagShift;

  // Request decode; op_d is the op that owns the block from the next cycle on.
  assign accept  = req_valid & ready_q;
  assign op_d    = accept ? req_op : op_q;
  assign arith_d = (op_d == OP_ADD) | (op_d == OP_ADC) | (op_d == OP_SUB) | (op_d == OP_SBC);
  assign shift_d = (op_d == OP_LSR) | (op_d == OP_ROR);
  assign long_op = arith_d | shift_d;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: multi-cycle ops walk IDLE -> EXEC -> FLAG -> IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (accept && long_op) state_d = ST_EXEC;
      ST_EXEC: state_d = ST_FLAG;
      ST_FLAG: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode from the upcoming state so every strobe is a flop output.
  always_comb begin
    active_d = (state_d == ST_EXEC) | (state_d == ST_FLAG);
    ready_d  = (state_d == ST_IDLE);
    sub_d    = active_d & ((op_d == OP_SUB) | (op_d == OP_SBC));
    cin_d    = active_d & ((op_d == OP_ADC) | (op_d == OP_SBC));
    shin_d   = active_d & (op_d == OP_ROR);
    bar_e_d  = ~(active_d & arith_d);
    bar_s_d  = ~(active_d & shift_d);
    trig_c_d = (state_d == ST_FLAG) & arith_d;
    trig_s_d = (state_d == ST_FLAG) & shift_d;
    done_d   = (state_q == ST_FLAG) | (accept & ~long_op);
  end

  // Registered control outputs; reset forces the idle/safe values.
  always_ff @(posedge clk) begin
    if (reset) begin
      ready_q  <= 1'b1;
      sub_q    <= 1'b0;
      cin_q    <= 1'b0;
      shin_q   <= 1'b0;
      bar_e_q  <= 1'b1;
      bar_s_q  <= 1'b1;
      trig_c_q <= 1'b0;
      trig_s_q <= 1'b0;
      done_q   <= 1'b0;
      rstb_q   <= 1'b0;
    end else begin
      ready_q  <= ready_d;
      sub_q    <= sub_d;
      cin_q    <= cin_d;
      shin_q   <= shin_d;
      bar_e_q  <= bar_e_d;
      bar_s_q  <= bar_s_d;
      trig_c_q <= trig_c_d;
      trig_s_q <= trig_s_d;
      done_q   <= done_d;
      rstb_q   <= 1'b1;
    end
  end

  // Operand/result next values; A takes the captured result only at the end of FLAG,
  // so the flag flops see the old A when the trigger rises.
  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    res_d = res_q;
    if (accept && (req_op == OP_LDA)) a_d = req_data;
    if (accept && arith_d)            b_d = req_data;
    if (state_q == ST_EXEC)           res_d = dbus;
    if (state_q == ST_FLAG)           a_d = res_q;
  end

  // Operand, result and op registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_q   <= '0;
      b_q   <= '0;
      res_q <= '0;
      op_q  <= OP_NOP;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      res_q <= res_d;
      op_q  <= op_d;
    end
  end

  assign resetBar   = rstb_q;
  assign req_ready  = ready_q;
  assign areg       = a_q;
  assign breg       = b_q;
  assign doSubtract = sub_q;
  assign doCarryIn  = cin_q;
  assign doShiftIn  = shin_q;
  assign assertBarE = bar_e_q;
  assign assertBarS = bar_s_q;
  assign triggerC   = trig_c_q;
  assign triggerS   = trig_s_q;
  assign done       = done_q;
  // Zero status is only meaningful on the completion pulse.
  assign zero       = done_q & aIsZero;

endmodule

// File: tb/tb_alu_sequencer.sv
// Testbench for alu_sequencer: behavioural ALU around the DUT, a reference model
// that computes expected results from the op rules, and a scoreboard monitor.
module tb_alu_sequencer;

  localparam logic [2:0] LDA = 3'd0;
  localparam logic [2:0] ADD = 3'd1;
  localparam logic [2:0] ADC = 3'd2;
  localparam logic [2:0] SUB = 3'd3;
  localparam logic [2:0] SBC = 3'd4;
  localparam logic [2:0] LSR = 3'd5;
  localparam logic [2:0] ROR = 3'd6;
  localparam logic [2:0] NOP = 3'd7;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       resetBar;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [2:0] req_op = 3'd0;
  logic [7:0] req_data = 8'd0;
  logic [7:0] areg, breg, dbus;
  logic       doSubtract, doCarryIn, doShiftIn;
  logic       assertBarE, assertBarS, triggerC, triggerS;
  logic       aIsZero, flagCarry, flagShift;
  logic       done, zero;

  alu_sequencer dut (
    .clk(clk), .reset(reset), .resetBar(resetBar),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_data(req_data),
    .areg(areg), .breg(breg),
    .doSubtract(doSubtract), .doCarryIn(doCarryIn), .doShiftIn(doShiftIn),
    .assertBarE(assertBarE), .assertBarS(assertBarS),
    .triggerC(triggerC), .triggerS(triggerS),
    .dbus(dbus), .aIsZero(aIsZero), .flagCarry(flagCarry), .flagShift(flagShift),
    .done(done), .zero(zero)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural ALU: adder/shifter onto dbus, flag flops clocked by the triggers.
  logic       fc = 1'b0;
  logic       fs = 1'b0;
  logic       alu_cin;
  logic [8:0] add_sum;
  assign alu_cin   = doCarryIn ? (doSubtract ? ~fc : fc) : doSubtract;
  assign add_sum   = {1'b0, areg} + {1'b0, (doSubtract ? ~breg : breg)} + {8'd0, alu_cin};
  assign dbus      = !assertBarE ? add_sum[7:0] :
                     !assertBarS ? {doShiftIn & fs, areg[7:1]} : 8'h00;
  assign aIsZero   = (areg == 8'h00);
  assign flagCarry = fc;
  assign flagShift = fs;

  always @(posedge triggerC or negedge resetBar)
    if (!resetBar) fc <= 1'b0; else fc <= add_sum[8];

  always @(posedge triggerS or negedge resetBar)
    if (!resetBar) fs <= 1'b0; else fs <= areg[0];

  // Scoreboard and reference state.
  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       c;
    logic       s;
    int         due;
  } exp_t;

  exp_t       sb_q[$];
  int         n_checks = 0;
  int         n_pass = 0;
  bit         mon_en = 1'b0;
  int         win_lo = -10;
  int         win_hi = -10;
  logic [2:0] win_op = NOP;
  logic [7:0] m_a = 8'd0;
  logic [7:0] m_b = 8'd0;
  logic       m_c = 1'b0;
  logic       m_s = 1'b0;

  task automatic chk(input string name, input int act, input int want);
    n_checks++;
    if (act == want) n_pass++;
    else $display("FAIL %s @cyc %0d: got 0x%0h want 0x%0h", name, cyc, act, want);
  endtask

  // Reference model: apply the op rules to the architectural state on acceptance.
  task automatic model_accept(input logic [2:0] op, input logic [7:0] d);
    logic [8:0] s;
    logic [7:0] na;
    int         lat;
    exp_t       e;
    lat = 3;
    case (op)
      LDA: begin m_a = d; lat = 1; end
      ADD: begin m_b = d; s = {1'b0, m_a} + {1'b0, d};                  m_a = s[7:0]; m_c = s[8]; end
      ADC: begin m_b = d; s = {1'b0, m_a} + {1'b0, d} + {8'd0, m_c};    m_a = s[7:0]; m_c = s[8]; end
      SUB: begin m_b = d; s = {1'b0, m_a} + {1'b0, ~d} + 9'd1;          m_a = s[7:0]; m_c = s[8]; end
      SBC: begin m_b = d; s = {1'b0, m_a} + {1'b0, ~d} + {8'd0, ~m_c};  m_a = s[7:0]; m_c = s[8]; end
      LSR: begin na = {1'b0, m_a[7:1]}; m_s = m_a[0]; m_a = na; end
      ROR: begin na = {m_s, m_a[7:1]};  m_s = m_a[0]; m_a = na; end
      default: lat = 1;
    endcase
    e.a = m_a; e.b = m_b; e.c = m_c; e.s = m_s; e.due = cyc + lat;
    sb_q.push_back(e);
    if (lat == 3) begin
      win_lo = cyc + 1;
      win_hi = cyc + 2;
      win_op = op;
    end
  endtask

  // Drive one cycle of request inputs; acc reports whether the next edge accepts.
  task automatic step(input bit v, input logic [2:0] op, input logic [7:0] d, output bit acc);
    @(negedge clk); #1;
    req_valid = v;
    req_op    = op;
    req_data  = d;
    acc = v && req_ready;
    if (acc) model_accept(op, d);
  endtask

  task automatic issue(input logic [2:0] op, input logic [7:0] d);
    bit acc;
    int g;
    acc = 1'b0;
    g = 0;
    while (!acc && g < 8) begin
      step(1'b1, op, d, acc);
      g++;
    end
    if (!acc) chk("issue_ready", 32'(req_ready), 1);
  endtask

  // Monitor: per-cycle control strobes against the active op window, and results on done.
  always @(negedge clk) begin : monitor
    logic       in_win, ar, sh;
    logic [8:0] want_ctrl, act_ctrl;
    exp_t       e;
    if (mon_en) begin
      in_win = (cyc >= win_lo) && (cyc <= win_hi);
      ar = (win_op == ADD) || (win_op == ADC) || (win_op == SUB) || (win_op == SBC);
      sh = (win_op == LSR) || (win_op == ROR);
      want_ctrl = {~in_win, ~(in_win & ar), ~(in_win & sh),
                   (cyc == win_hi) & ar, (cyc == win_hi) & sh,
                   in_win & ((win_op == SUB) || (win_op == SBC)),
                   in_win & ((win_op == ADC) || (win_op == SBC)),
                   in_win & (win_op == ROR), 1'b0};
      act_ctrl  = {req_ready, assertBarE, assertBarS, triggerC, triggerS,
                   doSubtract, doCarryIn, doShiftIn, zero & ~done};
      chk("ctrl", 32'(act_ctrl), 32'(want_ctrl));
      if (done) begin
        if (sb_q.size() == 0) begin
          chk("done_unexpected", 32'(done), 0);
        end else begin
          e = sb_q.pop_front();
          chk("done_cycle", cyc, e.due);
          chk("areg", 32'(areg), 32'(e.a));
          chk("breg", 32'(breg), 32'(e.b));
          chk("zero", 32'(zero), 32'(e.a == 8'h00));
          chk("carry_flag", 32'(flagCarry), 32'(e.c));
          chk("shift_flag", 32'(flagShift), 32'(e.s));
        end
      end else if (sb_q.size() != 0 && sb_q[0].due < cyc) begin
        chk("done_timeout", 32'(done), 1);
        void'(sb_q.pop_front());
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin : driver
    bit         acc;
    logic [2:0] op;
    logic [7:0] d;

    // Reset state.
    reset = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_resetBar", 32'(resetBar), 0);
    chk("rst_areg", 32'(areg), 0);
    chk("rst_breg", 32'(breg), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_ctrl", 32'({assertBarE, assertBarS, triggerC, triggerS,
                         doSubtract, doCarryIn, doShiftIn, zero}), 32'h0C0);
    reset = 1'b0;
    @(negedge clk); #1;
    chk("post_rst_ready", 32'(req_ready), 1);
    chk("post_rst_resetBar", 32'(resetBar), 1);
    mon_en = 1'b1;

    // Directed sequences.
    issue(LDA, 8'h3C);
    issue(LDA, 8'hF0);
    issue(ADD, 8'h20);
    issue(ADC, 8'h01);
    issue(LDA, 8'h05);
    issue(SUB, 8'h05);
    issue(SBC, 8'h01);
    issue(LDA, 8'h81);
    issue(LSR, 8'h00);
    issue(ROR, 8'h00);
    issue(NOP, 8'hAA);

    // Valid held high with ADDs: accepts every third cycle.
    for (int i = 0; i < 8; i++) step(1'b1, ADD, 8'(i * 17 + 3), acc);
    repeat (3) step(1'b0, NOP, 8'h00, acc);

    // Reset in FLAG aborts the op.
    issue(LDA, 8'h01);
    issue(ADD, 8'hFF);
    @(negedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk); #1;
    chk("abort_trigC_in_flag", 32'(triggerC), 1);
    chk("abort_carry_captured", 32'(flagCarry), 1);
    mon_en = 1'b0;
    sb_q.delete();
    reset = 1'b1;
    @(negedge clk); #1;
    chk("abort_areg", 32'(areg), 0);
    chk("abort_breg", 32'(breg), 0);
    chk("abort_trigC", 32'(triggerC), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_resetBar", 32'(resetBar), 0);
    chk("abort_carry_clr", 32'(flagCarry), 0);
    reset = 1'b0;
    @(negedge clk); #1;
    chk("abort_ready", 32'(req_ready), 1);
    chk("abort_done2", 32'(done), 0);
    chk("abort_areg2", 32'(areg), 0);
    m_a = 8'd0; m_b = 8'd0; m_c = 1'b0; m_s = 1'b0;
    win_lo = -10; win_hi = -10;
    mon_en = 1'b1;

    // Randomized traffic.
    for (int i = 0; i < 500; i++) begin
      op = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0:       d = m_a;
        1:       d = 8'h00;
        default: d = 8'($urandom_range(0, 255));
      endcase
      step($urandom_range(0, 3) != 0, op, d, acc);
    end

    repeat (6) step(1'b0, NOP, 8'h00, acc);
    chk("scoreboard_empty", sb_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
